// File: rtl/alu_op_driver.sv
// alu_op_driver: FIFO-buffered command initiator for the 4-bit ALU pin interface; define ALU_DRV_CHECK_EN for golden-model result checking
module alu_op_driver #(
  parameter int DEPTH   = 4,
  parameter int LATENCY = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  input  logic [2:0] cmd_op,
  output logic [7:0] alu_ui,
  output logic [2:0] alu_sel,
  input  logic [7:0] alu_y,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_mismatch,
  output logic [7:0] ops_done,
  output logic [7:0] err_count
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic [10:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [3:0] cnt;
  logic [10:0] head;
  logic push, pop, sample;
  assign cmd_ready = count != (AW+1)'(DEPTH);
  assign push = cmd_valid & cmd_ready;
  assign pop = (state == IDLE) & (count != '0);
  assign sample = (state == WAIT) & (cnt == '0);
  assign head = mem[rd_ptr];
  // command storage: {op, b, a}
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_op, cmd_b, cmd_a};
  end
  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
      count  <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  // next-state: issue, wait out the ALU latency, hold response until accepted
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = pop ? WAIT : IDLE;
      WAIT:    state_nx = sample ? RESP : WAIT;
      RESP:    state_nx = rsp_ready ? IDLE : RESP;
      default: state_nx = IDLE;
    endcase
  end
  // ALU pin drive, latency counter, response capture and completion count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_ui    <= '0;
      alu_sel   <= '0;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      ops_done  <= '0;
    end else begin
      if (pop) begin
        alu_ui  <= head[7:0];
        alu_sel <= head[10:8];
        cnt     <= 4'(LATENCY - 1);
      end
      if (state == WAIT && cnt != '0) cnt <= cnt - 1'b1;
      if (sample) begin
        rsp_data  <= alu_y;
        rsp_valid <= 1'b1;
      end
      if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
        ops_done  <= ops_done + 1'b1;
      end
    end
  end
`ifdef ALU_DRV_CHECK_EN
  logic [7:0] expect_y;
  function automatic logic [7:0] golden(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    logic [7:0] a8, b8;
    a8 = {4'h0, a};
    b8 = {4'h0, b};
    unique case (op)
      3'd0:    golden = a8 + b8;
      3'd1:    golden = a8 - b8;
      3'd2:    golden = a8 & b8;
      3'd3:    golden = a8 | b8;
      3'd4:    golden = a8 ^ b8;
      3'd5:    golden = {4'hF, ~a};
      3'd6:    golden = a8 >> 1;
      default: golden = a8 << 1;
    endcase
  endfunction
  // expected result latched at issue, compared at the sampling edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      expect_y     <= '0;
      rsp_mismatch <= 1'b0;
      err_count    <= '0;
    end else begin
      if (pop) expect_y <= golden(head[3:0], head[7:4], head[10:8]);
      if (sample) begin
        rsp_mismatch <= alu_y != expect_y;
        if (alu_y != expect_y && err_count != 8'hFF) err_count <= err_count + 1'b1;
      end
    end
  end
`else
  assign rsp_mismatch = 1'b0;
  assign err_count = '0;
`endif
endmodule

// File: tb/tb_alu_op_driver.sv
// tb_alu_op_driver: directed bench with a transaction scoreboard and a behavioural ALU
module tb_alu_op_driver;
  localparam int DEPTH = 4;
  localparam int LATENCY = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic [3:0] cmd_a = '0, cmd_b = '0;
  logic [2:0] cmd_op = '0;
  logic [7:0] alu_ui;
  logic [2:0] alu_sel;
  logic [7:0] alu_y = '0;
  logic rsp_valid;
  logic rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic rsp_mismatch;
  logic [7:0] ops_done, err_count;
  int total = 0;
  int bad = 0;
`ifdef ALU_DRV_CHECK_EN
  localparam bit CHECK = 1'b1;
`else
  localparam bit CHECK = 1'b0;
`endif
  typedef struct packed {logic [3:0] a; logic [3:0] b; logic [2:0] op;} cmd_t;
  cmd_t q[$];
  logic [7:0] ops_m = '0;
  logic [7:0] err_m = '0;
  logic [7:0] ui_q = '0;
  logic [2:0] sel_q = '0;

  alu_op_driver #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .alu_ui(alu_ui), .alu_sel(alu_sel),
    .alu_y(alu_y), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_mismatch(rsp_mismatch), .ops_done(ops_done), .err_count(err_count)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_fn(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    int x, y, r;
    x = int'(a);
    y = int'(b);
    case (op)
      3'd0: r = x + y;
      3'd1: r = x - y;
      3'd2: r = int'(a & b);
      3'd3: r = int'(a | b);
      3'd4: r = int'(a ^ b);
      3'd5: r = 255 - x;
      3'd6: r = x / 2;
      default: r = x * 2;
    endcase
    return 8'(r & 255);
  endfunction

  function automatic bit corrupt(input cmd_t c);
    return c.op == 3'd0 && c.a == 4'd1 && c.b == 4'd1;
  endfunction

  function automatic logic [7:0] sat(input int v);
    return v > 255 ? 8'd255 : 8'(v);
  endfunction

  // behavioural ALU: registers pins on rising edge, drives Y on falling edge, faulty for add 1+1
  always @(posedge clk) begin
    ui_q <= alu_ui;
    sel_q <= alu_sel;
  end
  always @(negedge clk)
    alu_y <= (sel_q == 3'd0 && ui_q == 8'h11) ? 8'h00 : alu_fn(ui_q[3:0], ui_q[7:4], sel_q);

  task automatic chk(input string n, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", n, act, exp, $time);
    end
  endtask

  // scoreboard: every response must match the oldest accepted command
  always @(negedge clk) begin
    cmd_t c;
    logic [7:0] ed;
    logic em;
    if (!rst_n) begin
      q.delete();
      ops_m = '0;
      err_m = '0;
    end else begin
      chk("ops_done", ops_done, ops_m);
      if (rsp_valid) begin
        if (q.size() == 0) chk("rsp_unexpected", {7'd0, rsp_valid}, 8'd0);
        else begin
          c = q[0];
          em = CHECK && corrupt(c);
          ed = corrupt(c) ? 8'h00 : alu_fn(c.a, c.b, c.op);
          chk("rsp_data", rsp_data, ed);
          chk("rsp_mismatch", {7'd0, rsp_mismatch}, {7'd0, em});
          chk("alu_ui_hold", alu_ui, {c.b, c.a});
          chk("alu_sel_hold", {5'd0, alu_sel}, {5'd0, c.op});
          chk("err_count", err_count, sat(int'(err_m) + int'(em)));
          if (rsp_ready) begin
            void'(q.pop_front());
            ops_m = ops_m + 8'd1;
            err_m = sat(int'(err_m) + int'(em));
          end
        end
      end else chk("err_count_idle", err_count, err_m);
      if (cmd_valid && cmd_ready) q.push_back('{cmd_a, cmd_b, cmd_op});
    end
  end

  task automatic push(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    int n;
    cmd_a = a;
    cmd_b = b;
    cmd_op = op;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cmd_ready) chk("push_timeout", {7'd0, cmd_ready}, 8'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    for (int n = 0; n < 100; n++) begin
      @(posedge clk); #1;
      if (rsp_valid) break;
    end
    if (!rsp_valid) chk("rsp_timeout", {7'd0, rsp_valid}, 8'd1);
  endtask

  task automatic ack();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op, input logic [7:0] exp);
    push(a, b, op);
    wait_rsp();
    chk("op_result", rsp_data, exp);
  endtask

  task automatic drain();
    for (int n = 0; n < 2000; n++) begin
      @(posedge clk); #1;
      if (q.size() == 0 && !rsp_valid) break;
    end
    chk("drain", 8'(q.size()), 8'd0);
  endtask

  task automatic chk_reset_outputs(input string n);
    chk({n, "_alu_ui"}, alu_ui, 8'h00);
    chk({n, "_alu_sel"}, {5'd0, alu_sel}, 8'h00);
    chk({n, "_rsp"}, {5'd0, rsp_valid, rsp_mismatch, 1'b0}, 8'h00);
    chk({n, "_rsp_data"}, rsp_data, 8'h00);
    chk({n, "_ops_done"}, ops_done, 8'h00);
    chk({n, "_err_count"}, err_count, 8'h00);
    chk({n, "_cmd_ready"}, {7'd0, cmd_ready}, 8'h01);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    // single add with exact timing
    push(4'd3, 4'd5, 3'd0);
    @(posedge clk); #1;
    chk("issue_ui", alu_ui, 8'h53);
    chk("issue_sel", {5'd0, alu_sel}, 8'h00);
    chk("early_valid", {7'd0, rsp_valid}, 8'h00);
    @(posedge clk); #1;
    chk("latency_valid_low", {7'd0, rsp_valid}, 8'h00);
    @(posedge clk); #1;
    chk("latency_valid_high", {7'd0, rsp_valid}, 8'h01);
    chk("add_data", rsp_data, 8'h08);
    chk("add_mismatch", {7'd0, rsp_mismatch}, 8'h00);
    ack();
    chk("ops_done_one", ops_done, 8'h01);
    chk("valid_cleared", {7'd0, rsp_valid}, 8'h00);
    // opcode sweep
    run_op(4'h3, 4'h5, 3'd1, 8'hFE); ack();
    run_op(4'h5, 4'h0, 3'd5, 8'hFA); ack();
    run_op(4'hF, 4'h0, 3'd7, 8'h1E); ack();
    run_op(4'h9, 4'h0, 3'd6, 8'h04); ack();
    run_op(4'hC, 4'hA, 3'd4, 8'h06);
    chk("sweep_err", err_count, 8'h00);
    ack();
    run_op(4'h6, 4'hA, 3'd2, 8'h02); ack();
    run_op(4'h6, 4'h9, 3'd3, 8'h0F); ack();
    // faulty ALU result
    run_op(4'h1, 4'h1, 3'd0, 8'h00);
    chk("fault_mismatch", {7'd0, rsp_mismatch}, {7'd0, CHECK});
    chk("fault_err", err_count, CHECK ? 8'h01 : 8'h00);
    ack();
    run_op(4'h2, 4'h3, 3'd0, 8'h05);
    chk("good_mismatch", {7'd0, rsp_mismatch}, 8'h00);
    chk("good_err", err_count, CHECK ? 8'h01 : 8'h00);
    ack();
    // backpressure: one in flight, four buffered, sixth stalled
    for (int i = 0; i < 5; i++) push(4'(i + 1), 4'(i + 2), 3'(i));
    chk("full_ready", {7'd0, cmd_ready}, 8'h00);
    cmd_a = 4'hE; cmd_b = 4'h7; cmd_op = 3'd4; cmd_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("stalled_ready", {7'd0, cmd_ready}, 8'h00);
    chk("stalled_queue", 8'(q.size()), 8'd5);
    rsp_ready = 1'b1;
    for (int n = 0; n < 100 && !cmd_ready; n++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    drain();
    rsp_ready = 1'b0;
    chk("stall_ops", ops_done, 8'd16);
    // asynchronous reset during WAIT with three queued
    push(4'h1, 4'h2, 3'd0);
    wait_rsp();
    for (int i = 0; i < 4; i++) push(4'(i), 4'h3, 3'd3);
    chk("rst_full", {7'd0, cmd_ready}, 8'h00);
    ack();
    @(posedge clk); #1;
    chk("rst_wait_ui", alu_ui, 8'h30);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("post_rst_valid", {7'd0, rsp_valid}, 8'h00);
    chk("post_rst_ops", ops_done, 8'h00);
    // ops_done wrap
    rsp_ready = 1'b1;
    for (int i = 0; i < 255; i++) push(4'(i), 4'(i >> 4), 3'(i));
    drain();
    chk("ops_255", ops_done, 8'hFF);
    push(4'h7, 4'h2, 3'd1);
    drain();
    chk("ops_wrap", ops_done, 8'h00);
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
